vec_store_engine: RTL
=====================

# vec_store_engine

Parametrised successor to the vector store unit. It moves `length` elements from a vector buffer to DRAM in whole tiles, writing BEAT_ELEMS elements per memory beat with byte strobes. It fully honours a valid/ready memory handshake and supports a configurable inter-tile destination stride. It sits between the shared vector buffer file and the DRAM arbiter, and is started by the instruction decoder for STORE instructions.

## Interface
- ADDR_WIDTH, 24, DRAM address width (element-addressed).
- DATA_WIDTH, 8, element width in bits.
- TILE_WIDTH, 256, buffer tile width in bits.
- TILE_ELEMS, TILE_WIDTH/DATA_WIDTH, elements per tile.
- BEAT_ELEMS, 4, elements per memory beat. TILE_ELEMS must be a multiple of BEAT_ELEMS; this is checked at elaboration.
- LEN_WIDTH, 16, width of the length field.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle start request. Accepted only in S_IDLE; ignored otherwise.
- dram_addr  in  ADDR_WIDTH  destination address of element 0.
- length  in  LEN_WIDTH  number of elements to store.
- stride  in  ADDR_WIDTH  address distance between tile bases. 0 means TILE_ELEMS (contiguous).
- buf_id  in  5  source buffer. Captured at start.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle completion pulse.
- buf_read_en  out  1  one-cycle tile read pulse.
- buf_read_id  out  5  the captured buf_id.
- buf_read_data  in  DATA_WIDTH x TILE_ELEMS  tile data, valid while buf_read_done is high.
- buf_read_done  in  1  tile data valid.
- mem_req  out  1  beat valid.
- mem_we  out  1  equal to mem_req.
- mem_addr  out  ADDR_WIDTH  beat address.
- mem_wdata  out  DATA_WIDTH*BEAT_ELEMS  beat data, element 0 in the LSBs.
- mem_wstrb  out  BEAT_ELEMS  per-element write enable.
- mem_ready  in  1  beat accepted when high together with mem_req at a clock edge.
- stall_cnt  out  16  memory stall counter (see Configuration).

## Operation
- States: S_IDLE, S_REQ_TILE, S_WAIT_TILE, S_WRITE, S_ADVANCE, S_FINISH.
- S_IDLE + start:
  - latch dram_addr, length, effective stride and buf_id; clear counters.
  - length==0 → S_FINISH; otherwise → S_REQ_TILE.
- S_REQ_TILE: assert buf_read_en for exactly one cycle, then → S_WAIT_TILE.
- S_WAIT_TILE: on buf_read_done, capture the full tile into the local tile register, then → S_WRITE. If buf_read_done arrives in the same cycle as buf_read_en, it is accepted.
- S_WRITE:
  - Beat k of the current tile: addr = tile_base + k*BEAT_ELEMS; data = elements [k*BEAT_ELEMS +: BEAT_ELEMS].
  - wstrb bit i is set iff (elements already written + i) < length. Inactive lanes carry zero data.
  - On handshake (mem_req && mem_ready): advance. After the last beat of the tile, or the last element of length, → S_ADVANCE.
- S_ADVANCE: if remaining > 0, tile_base += stride and → S_REQ_TILE; else → S_FINISH.
- S_FINISH: done=1 for one cycle, busy=0, → S_IDLE.
- Beats per tile = ceil(min(remaining, TILE_ELEMS)/BEAT_ELEMS).
- All address arithmetic wraps modulo 2^ADDR_WIDTH. Element counters are LEN_WIDTH+1 bits wide, so they cannot overflow.
- buf_read_data is sampled only on buf_read_done. Later changes on that bus do not affect the beats being written.

## Timing
- Reset value of every output is 0, including buf_read_id, mem_addr, mem_wdata and stall_cnt. Reset mid-operation abandons the transfer with no done pulse; a start one cycle after reset release is accepted.
- start accepted at edge T → busy high from T+1; buf_read_en high during T+1 only.
- mem_req rises the cycle after buf_read_done is captured.
- mem_req, mem_addr, mem_wdata and mem_wstrb stay stable while mem_req && !mem_ready. mem_req never drops without a handshake.
- With mem_ready tied high, beats are issued back-to-back, one per cycle.
- The tile transition costs 2 cycles plus the buffer latency (S_ADVANCE, then S_REQ_TILE).
- done is high in the cycle after the final handshake passes through S_ADVANCE. For length==0, done is high at T+1 and buf_read_en and mem_req never assert.

## Configuration
- STORE_STALL_CNT_EN defined:
  - stall_cnt increments by one in every cycle where mem_req && !mem_ready, saturating at 0xFFFF.
  - It clears on start acceptance and holds its value after done.
- Not defined: stall_cnt is tied to 0 and the counter logic is not compiled.

## Structure
- vec_store_pkg holds the state enum, the BEAT_ELEMS/TILE_ELEMS divisibility check function, and a strobe-mask helper.
- One sub-module, vec_store_beat_mux, is natural. It is combinational: from the tile register, beat index and remaining count it produces mem_wdata and mem_wstrb.

## Test plan
- dram_addr=0x100, length=32, mem_ready=1 → 8 beats at 0x100..0x11C in steps of 4, wstrb=0xF each, one buf_read_en, done once.
- length=37, stride=0 → 2 tiles and 10 beats. Last beat at 0x124 with wstrb=0x1 and upper lanes zero. Exactly two buf_read_en pulses.
- mem_ready low for 3 cycles during beat 2 → addr/data/wstrb held for those cycles. stall_cnt=3 with STORE_STALL_CNT_EN, 0 without.
- length=0 → no buf_read_en, no mem_req; done at T+1.
- stride=0x100, dram_addr=0x40, length=64 → tile 1 beats start at 0x140.
- rst asserted while mem_req is high and stalled → all outputs 0 immediately. A new start with length=4 then completes with 1 beat.

Source files
------------

// File: rtl/vec_store_pkg.sv
// Shared types and helpers for the vector store engine: FSM state encoding,
// the tile/beat divisibility check and the per-lane write-strobe rule.
package vec_store_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ_TILE  = 3'd1,
    S_WAIT_TILE = 3'd2,
    S_WRITE     = 3'd3,
    S_ADVANCE   = 3'd4,
    S_FINISH    = 3'd5
  } state_t;

  function automatic bit beats_divide_tile(input int tile_elems, input int beat_elems);
    return (beat_elems > 0) && ((tile_elems % beat_elems) == 0);
  endfunction

  // A lane is written only while it still falls inside the requested length.
  function automatic logic strb_lane(input logic [31:0] remaining, input int lane);
    return 32'(lane) < remaining;
  endfunction

endpackage

// File: rtl/vec_store_beat_mux.sv
// Combinational beat selector: picks beat i_beat out of the tile register and
// masks lanes past the end of the transfer (strobe low, data forced to zero).
module vec_store_beat_mux
  import vec_store_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int TILE_ELEMS = 32,
  parameter int BEAT_ELEMS = 4,
  parameter int BEAT_IDX_W = 3,
  parameter int LEN_WIDTH  = 16
) (
  input  logic [DATA_WIDTH*TILE_ELEMS-1:0] i_tile,
  input  logic [BEAT_IDX_W-1:0]            i_beat,
  input  logic [LEN_WIDTH:0]               i_remaining,
  output logic [DATA_WIDTH*BEAT_ELEMS-1:0] o_wdata,
  output logic [BEAT_ELEMS-1:0]            o_wstrb
);

  always_comb begin
    o_wdata = '0;
    o_wstrb = '0;
    for (int i = 0; i < BEAT_ELEMS; i++) begin
      o_wstrb[i] = strb_lane(32'(i_remaining), i);
      if (strb_lane(32'(i_remaining), i)) begin
        o_wdata[i*DATA_WIDTH +: DATA_WIDTH] =
          i_tile[(int'(i_beat)*BEAT_ELEMS + i)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/vec_store_engine.sv
// Vector store engine: streams length elements from a buffer tile to DRAM in
// strobed beats, one tile at a time. Define STORE_STALL_CNT_EN to build the stall counter.
module vec_store_engine
  import vec_store_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 8,
  parameter int TILE_WIDTH = 256,
  parameter int TILE_ELEMS = TILE_WIDTH / DATA_WIDTH,
  parameter int BEAT_ELEMS = 4,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            dram_addr,
  input  logic [LEN_WIDTH-1:0]             length,
  input  logic [ADDR_WIDTH-1:0]            stride,
  input  logic [4:0]                       buf_id,
  output logic                             busy,
  output logic                             done,
  output logic                             buf_read_en,
  output logic [4:0]                       buf_read_id,
  input  logic [TILE_WIDTH-1:0]            buf_read_data,
  input  logic                             buf_read_done,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH*BEAT_ELEMS-1:0] mem_wdata,
  output logic [BEAT_ELEMS-1:0]            mem_wstrb,
  input  logic                             mem_ready,
  output logic [15:0]                      stall_cnt,
  output logic [2:0]                       o_dbg_state
);

  localparam int BEATS      = TILE_ELEMS / BEAT_ELEMS;
  localparam int BEAT_IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W      = LEN_WIDTH + 1;

  if (!beats_divide_tile(TILE_ELEMS, BEAT_ELEMS)) begin : g_bad_beat_cfg
    $error("vec_store_engine: TILE_ELEMS must be a multiple of BEAT_ELEMS");
  end

  state_t                          r_state;
  state_t                          w_next;
  logic [ADDR_WIDTH-1:0]           r_base;
  logic [ADDR_WIDTH-1:0]           r_stride;
  logic [CNT_W-1:0]                r_len;
  logic [CNT_W-1:0]                r_written;
  logic [4:0]                      r_buf_id;
  logic [TILE_WIDTH-1:0]           r_tile;
  logic [BEAT_IDX_W-1:0]           r_beat;

  logic                            w_accept;
  logic                            w_tile_take;
  logic                            w_hs;
  logic                            w_last_beat;
  logic [CNT_W-1:0]                w_remaining;
  logic [CNT_W-1:0]                w_step;
  logic [DATA_WIDTH*BEAT_ELEMS-1:0] w_wdata;
  logic [BEAT_ELEMS-1:0]           w_wstrb;

  // Memory handshake: a beat transfers on a rising clk edge where mem_req and
  // mem_ready are both high; until then the beat (addr/data/strb) is held and
  // mem_req stays asserted.
  assign w_accept    = start && (r_state == S_IDLE);
  assign w_tile_take = buf_read_done && ((r_state == S_REQ_TILE) || (r_state == S_WAIT_TILE));
  assign w_hs        = (r_state == S_WRITE) && mem_ready;
  assign w_remaining = r_len - r_written;
  assign w_step      = (w_remaining < CNT_W'(BEAT_ELEMS)) ? w_remaining : CNT_W'(BEAT_ELEMS);
  assign w_last_beat = (r_beat == BEAT_IDX_W'(BEATS - 1)) || (w_remaining <= CNT_W'(BEAT_ELEMS));

  vec_store_beat_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .TILE_ELEMS (TILE_ELEMS),
    .BEAT_ELEMS (BEAT_ELEMS),
    .BEAT_IDX_W (BEAT_IDX_W),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_beat_mux (
    .i_tile      (r_tile),
    .i_beat      (r_beat),
    .i_remaining (w_remaining),
    .o_wdata     (w_wdata),
    .o_wstrb     (w_wstrb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (start) w_next = (length == '0) ? S_FINISH : S_REQ_TILE;
      S_REQ_TILE:  w_next = buf_read_done ? S_WRITE : S_WAIT_TILE;
      S_WAIT_TILE: if (buf_read_done) w_next = S_WRITE;
      S_WRITE:     if (mem_ready && w_last_beat) w_next = S_ADVANCE;
      S_ADVANCE:   w_next = (w_remaining != '0) ? S_REQ_TILE : S_FINISH;
      S_FINISH:    w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    buf_read_en = 1'b0;
    mem_req     = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wstrb   = '0;
    case (r_state)
      S_REQ_TILE: begin
        busy        = 1'b1;
        buf_read_en = 1'b1;
      end
      S_WAIT_TILE, S_ADVANCE: busy = 1'b1;
      S_WRITE: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = r_base + ADDR_WIDTH'(r_beat) * ADDR_WIDTH'(BEAT_ELEMS);
        mem_wdata = w_wdata;
        mem_wstrb = w_wstrb;
      end
      S_FINISH: done = 1'b1;
      default: ;
    endcase
  end

  assign mem_we      = mem_req;
  assign buf_read_id = r_buf_id;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base    <= '0;
      r_stride  <= '0;
      r_len     <= '0;
      r_written <= '0;
      r_buf_id  <= '0;
      r_tile    <= '0;
      r_beat    <= '0;
    end else begin
      if (w_accept) begin
        r_base    <= dram_addr;
        r_stride  <= (stride == '0) ? ADDR_WIDTH'(TILE_ELEMS) : stride;
        r_len     <= {1'b0, length};
        r_written <= '0;
        r_buf_id  <= buf_id;
        r_beat    <= '0;
      end
      // The tile is copied once so later activity on the buffer bus cannot leak into beats.
      if (w_tile_take) begin
        r_tile <= buf_read_data;
        r_beat <= '0;
      end
      if (w_hs) begin
        r_written <= r_written + w_step;
        r_beat    <= r_beat + BEAT_IDX_W'(1);
      end
      if ((r_state == S_ADVANCE) && (w_remaining != '0)) begin
        r_base <= r_base + r_stride;
      end
    end
  end

`ifdef STORE_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_accept) begin
      r_stall_cnt <= '0;
    end else if (mem_req && !mem_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule
